// File: rtl/button_event_pkg.sv
// Shared constants for the UI button path: event codes, per-button FSM
// encoding and the timing defaults derived from the system clock rate.
package button_event_pkg;

  // System clock rate; the debouncer derives its own windows from the same base.
  localparam int CLK_FREQ_HZ     = 100_000_000;

  // UI timing defaults: 1 s to long-press, 200 ms between auto-repeats.
  localparam int UI_LONG_TICKS   = CLK_FREQ_HZ;
  localparam int UI_REPEAT_TICKS = CLK_FREQ_HZ / 5;
  localparam int UI_CNT_W        = 27;

  // Event type codes; the numeric order is also the in-button priority.
  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  // One pending flag per event type per button.
  localparam int EVT_PER_BTN     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_event_fsm.sv
// Per-button tracker: turns one debounced level into press, release,
// long-press and auto-repeat pulses. All outputs are registered.
// (release and repeat are reserved words, hence the _pulse suffix.)
module btn_event_fsm
  import button_event_pkg::*;
#(
  parameter int LONG_TICKS   = UI_LONG_TICKS,
  parameter int REPEAT_TICKS = UI_REPEAT_TICKS,
  parameter int CNT_W        = UI_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

  btn_state_e       state_r;
  btn_state_e       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             press_nx_s;
  logic             release_nx_s;
  logic             long_nx_s;
  logic             repeat_nx_s;

  // Next state, hold counter and pulse decode; release wins over a due threshold.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    press_nx_s   = 1'b0;
    release_nx_s = 1'b0;
    long_nx_s    = 1'b0;
    repeat_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (level) begin
          state_nx_s = ST_DOWN;
          cnt_nx_s   = CNT_ZERO;
          press_nx_s = 1'b1;
        end else begin
          cnt_nx_s   = CNT_ZERO;
        end
      end
      ST_DOWN: begin
        if (!level) begin
          state_nx_s   = ST_IDLE;
          cnt_nx_s     = CNT_ZERO;
          release_nx_s = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          state_nx_s   = ST_LONG;
          cnt_nx_s     = CNT_ZERO;
          long_nx_s    = 1'b1;
        end else begin
          cnt_nx_s     = cnt_r + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (!level) begin
          state_nx_s   = ST_IDLE;
          cnt_nx_s     = CNT_ZERO;
          release_nx_s = 1'b1;
        end else if (cnt_r == REPEAT_LAST) begin
          cnt_nx_s     = CNT_ZERO;
          repeat_nx_s  = 1'b1;
        end else begin
          cnt_nx_s     = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered pulse/held outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      press         <= press_nx_s;
      release_pulse <= release_nx_s;
      long_press    <= long_nx_s;
      repeat_pulse  <= repeat_nx_s;
      held          <= (state_nx_s == ST_LONG);
    end
  end

endmodule

// File: rtl/button_event.sv
// Button event generator: per-button FSMs produce pulses, which are latched
// into sticky pending flags and drained one at a time through a single-entry
// valid/ready channel (lowest button first, press > release > long > repeat).
module button_event
  import button_event_pkg::*;
#(
  parameter int NUM_BTN      = 5,
  parameter int LONG_TICKS   = UI_LONG_TICKS,
  parameter int REPEAT_TICKS = UI_REPEAT_TICKS,
  parameter int CNT_W        = UI_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_press,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic [NUM_BTN-1:0] held,
  output logic               evt_valid,
  output logic [2:0]         evt_btn,
  output logic [1:0]         evt_type,
  input  logic               evt_ready,
  output logic               evt_ovf
);

  // Flag index is btn*4 + type, so the lowest set index is the winner.
  localparam int NF    = NUM_BTN * EVT_PER_BTN;
  localparam int IDX_W = 5;

  logic [NF-1:0]    pend_r;
  logic [NF-1:0]    set_s;
  logic [NF-1:0]    first_s;
  logic [NF-1:0]    clr_s;
  logic [NF-1:0]    drop_s;
  logic [NF-1:0]    pend_nx_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             load_s;
  logic             any_s;
  logic             evt_valid_nx_s;
  logic [2:0]       evt_btn_nx_s;
  logic [1:0]       evt_type_nx_s;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_event_fsm #(
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS),
        .CNT_W        (CNT_W)
      ) u_fsm (
        .clock         (clock),
        .reset         (reset),
        .level         (btn_level[g]),
        .press         (press[g]),
        .release_pulse (release_pulse[g]),
        .long_press    (long_press[g]),
        .repeat_pulse  (repeat_pulse[g]),
        .held          (held[g])
      );
    end
  endgenerate

  // Gather the registered pulses into the flag-ordered set vector.
  always_comb begin
    set_s = {NF{1'b0}};
    for (int b = 0; b < NUM_BTN; b++) begin
      set_s[b*EVT_PER_BTN + int'(EVT_PRESS)]   = press[b];
      set_s[b*EVT_PER_BTN + int'(EVT_RELEASE)] = release_pulse[b];
      set_s[b*EVT_PER_BTN + int'(EVT_LONG)]    = long_press[b];
      set_s[b*EVT_PER_BTN + int'(EVT_REPEAT)]  = repeat_pulse[b];
    end
  end

  // Isolate the lowest pending flag and encode its index.
  always_comb begin
    first_s   = pend_r & (~pend_r + NF'(1'b1));
    sel_idx_s = {IDX_W{1'b0}};
    for (int k = 0; k < NF; k++) begin
      sel_idx_s = sel_idx_s | (first_s[k] ? IDX_W'(k) : {IDX_W{1'b0}});
    end
  end

  // Flag bookkeeping: a flag loaded this cycle may be re-set without a drop.
  always_comb begin
    load_s    = !evt_valid || evt_ready;
    any_s     = |pend_r;
    clr_s     = load_s ? first_s : {NF{1'b0}};
    drop_s    = set_s & pend_r & ~clr_s;
    pend_nx_s = (pend_r & ~clr_s) | set_s;
  end

  // Holding register next value; contents stay frozen while stalled.
  always_comb begin
    evt_valid_nx_s = evt_valid;
    evt_btn_nx_s   = evt_btn;
    evt_type_nx_s  = evt_type;
    if (load_s) begin
      if (any_s) begin
        evt_valid_nx_s = 1'b1;
        evt_btn_nx_s   = sel_idx_s[4:2];
        evt_type_nx_s  = sel_idx_s[1:0];
      end else begin
        evt_valid_nx_s = 1'b0;
        evt_btn_nx_s   = 3'd0;
        evt_type_nx_s  = 2'd0;
      end
    end else begin
      evt_valid_nx_s = evt_valid;
      evt_btn_nx_s   = evt_btn;
      evt_type_nx_s  = evt_type;
    end
  end

  // Pending flags, event channel and overflow pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r    <= {NF{1'b0}};
      evt_valid <= 1'b0;
      evt_btn   <= 3'd0;
      evt_type  <= 2'd0;
      evt_ovf   <= 1'b0;
    end else begin
      pend_r    <= pend_nx_s;
      evt_valid <= evt_valid_nx_s;
      evt_btn   <= evt_btn_nx_s;
      evt_type  <= evt_type_nx_s;
      evt_ovf   <= |drop_s;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event (LONG_TICKS=8, REPEAT_TICKS=4).
// The reference model works from hold run-lengths and an event-level flag
// table, updated once per clock edge from the same inputs the DUT samples.
`timescale 1ns/1ps
module tb_button_event;

  localparam int NB = 5;
  localparam int LT = 8;
  localparam int RT = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press, release_pulse, long_press, repeat_pulse, held;
  logic          evt_valid, evt_ready, evt_ovf;
  logic [2:0]    evt_btn;
  logic [1:0]    evt_type;
  logic [31:0]   obs;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [4:0] acc_q[$];
  int         acc_c[$];

  // Reference model state
  int            run_m [NB];
  bit            pend_m [NB*4];
  logic [NB-1:0] m_press = '0, m_rel = '0, m_long = '0, m_rep = '0, m_held = '0;
  logic          m_valid = 1'b0, m_ovf = 1'b0;
  logic [2:0]    m_btn = 3'd0;
  logic [1:0]    m_type = 2'd0;

  always #5 clock = ~clock;

  button_event #(
    .NUM_BTN(NB), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .btn_level(btn_level),
    .press(press), .release_pulse(release_pulse), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .held(held),
    .evt_valid(evt_valid), .evt_btn(evt_btn), .evt_type(evt_type),
    .evt_ready(evt_ready), .evt_ovf(evt_ovf)
  );

  assign obs = {press, release_pulse, long_press, repeat_pulse, held,
                evt_valid, evt_btn, evt_type, evt_ovf};

  function automatic logic [31:0] exp_all();
    return {m_press, m_rel, m_long, m_rep, m_held, m_valid, m_btn, m_type, m_ovf};
  endfunction

  // One clock edge of the reference model.
  task automatic model_edge();
    logic [NB-1:0] ov [4];
    bit take;
    int pick;
    if (reset) begin
      for (int b = 0; b < NB; b++) run_m[b] = 0;
      for (int k = 0; k < NB*4; k++) pend_m[k] = 1'b0;
      m_press = '0; m_rel = '0; m_long = '0; m_rep = '0; m_held = '0;
      m_valid = 1'b0; m_btn = 3'd0; m_type = 2'd0; m_ovf = 1'b0;
      return;
    end
    ov[0] = m_press; ov[1] = m_rel; ov[2] = m_long; ov[3] = m_rep;
    take = !m_valid || evt_ready;
    pick = -1;
    for (int k = 0; k < NB*4; k++) if (pend_m[k] && pick < 0) pick = k;
    if (take) begin
      m_valid = (pick >= 0);
      m_btn   = (pick >= 0) ? 3'(pick / 4) : 3'd0;
      m_type  = (pick >= 0) ? 2'(pick % 4) : 2'd0;
      if (pick >= 0) pend_m[pick] = 1'b0;
    end
    m_ovf = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int t = 0; t < 4; t++)
        if (ov[t][b]) begin
          if (pend_m[b*4+t]) m_ovf = 1'b1;
          pend_m[b*4+t] = 1'b1;
        end
    for (int b = 0; b < NB; b++) begin
      m_press[b] = 1'b0; m_rel[b] = 1'b0; m_long[b] = 1'b0; m_rep[b] = 1'b0;
      if (btn_level[b]) begin
        run_m[b]++;
        m_press[b] = (run_m[b] == 1);
        m_long[b]  = (run_m[b] == LT + 1);
        m_rep[b]   = (run_m[b] > LT + 1) && (((run_m[b] - LT - 1) % RT) == 0);
      end else begin
        m_rel[b] = (run_m[b] > 0);
        run_m[b] = 0;
      end
      m_held[b] = (run_m[b] >= LT + 1);
    end
  endtask

  // Advance one clock: log accepted events, update model, sample after edge.
  task automatic step();
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      acc_q.push_back({evt_btn, evt_type});
      acc_c.push_back(cyc);
    end
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    btn_level = '0;
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_level = '0; evt_ready = 1'b0;
    step(); step();
    compared++;
    if (obs !== 32'd0) begin
      mismatched++; $display("FAIL reset_outputs: got %h expected %h", obs, 32'd0);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_press_release();
    acc_q.delete(); acc_c.delete();
    evt_ready = 1'b1; btn_level = 5'b00100;
    step();
    compared++;
    if (press !== 5'b00100) begin
      mismatched++; $display("FAIL pr_press: got %b expected %b", press, 5'b00100);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      compared++;
      if (obs !== exp_all()) begin
        mismatched++; $display("FAIL pr_hold: got %h expected %h", obs, exp_all());
      end
    end
    btn_level = 5'b00000;
    step();
    compared++;
    if (release_pulse !== 5'b00100) begin
      mismatched++; $display("FAIL pr_release: got %b expected %b", release_pulse, 5'b00100);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      compared++;
      if (obs !== exp_all() || long_press !== 5'b00000) begin
        mismatched++; $display("FAIL pr_after: got %h expected %h", obs, exp_all());
      end
    end
    compared++;
    if (acc_q.size() != 2 || acc_q[0] !== 5'b01000 || acc_q[1] !== 5'b01001) begin
      mismatched++;
      $display("FAIL pr_events: got n=%0d first=%b expected n=2 {01000,01001}",
               acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 5'b11111);
    end
    idle(4);
  endtask

  task automatic test_long_repeat();
    int long_c;
    int rep_c[$];
    long_c = -1;
    evt_ready = 1'b1; btn_level = 5'b00001;
    step();
    for (int c = 1; c <= 20; c++) begin
      step();
      compared++;
      if (obs !== exp_all()) begin
        mismatched++; $display("FAIL long_cycle%0d: got %h expected %h", c, obs, exp_all());
      end
      if (long_press[0] === 1'b1 && long_c < 0) long_c = c;
      if (repeat_pulse[0] === 1'b1) rep_c.push_back(c);
      if (c == 7 || c == 8) begin
        compared++;
        if (held[0] !== (c == 8)) begin
          mismatched++; $display("FAIL long_held_c%0d: got %b expected %b", c, held[0], (c == 8));
        end
      end
    end
    compared++;
    if (long_c != 8) begin
      mismatched++; $display("FAIL long_delay: got %0d expected 8", long_c);
    end
    compared++;
    if (rep_c.size() < 2 || rep_c[0] != 12 || rep_c[1] != 16) begin
      mismatched++; $display("FAIL repeat_times: got n=%0d expected 12,16,...", rep_c.size());
    end
    btn_level = 5'b00000;
    step();
    compared++;
    if (release_pulse[0] !== 1'b1 || held[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL long_release: got rel=%b held=%b expected rel=1 held=0", release_pulse[0], held[0]);
    end
    idle(10);
  endtask

  task automatic test_simultaneous();
    acc_q.delete(); acc_c.delete();
    evt_ready = 1'b1; btn_level = 5'b01010;
    step();
    compared++;
    if (press !== 5'b01010) begin
      mismatched++; $display("FAIL sim_press: got %b expected %b", press, 5'b01010);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      compared++;
      if (obs !== exp_all()) begin
        mismatched++; $display("FAIL sim_cycle: got %h expected %h", obs, exp_all());
      end
    end
    compared++;
    if (acc_q.size() < 2 || acc_q[0] !== 5'b00100 || acc_q[1] !== 5'b01100 ||
        acc_c[1] - acc_c[0] != 1) begin
      mismatched++; $display("FAIL sim_order: got n=%0d expected btn1 then btn3 back to back", acc_q.size());
    end
    idle(12);
  endtask

  task automatic test_stall_ovf();
    bit [11:0] patv;
    int ovf_n;
    patv = 12'b0000_0011_0011;
    ovf_n = 0;
    evt_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      btn_level = {4'b0000, patv[c]};
      step();
      compared++;
      if (obs !== exp_all()) begin
        mismatched++; $display("FAIL stall_cycle%0d: got %h expected %h", c, obs, exp_all());
      end
      if (evt_ovf === 1'b1) ovf_n++;
      if (c >= 2) begin
        compared++;
        if ({evt_valid, evt_btn, evt_type} !== 6'b1_000_00) begin
          mismatched++; $display("FAIL stall_hold%0d: got %b expected %b", c,
                                 {evt_valid, evt_btn, evt_type}, 6'b1_000_00);
        end
      end
    end
    compared++;
    if (ovf_n != 1) begin
      mismatched++; $display("FAIL ovf_count: got %0d expected 1", ovf_n);
    end
    acc_q.delete(); acc_c.delete();
    evt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      compared++;
      if (obs !== exp_all()) begin
        mismatched++; $display("FAIL drain_cycle: got %h expected %h", obs, exp_all());
      end
    end
    compared++;
    if (acc_q.size() != 3 || acc_q[0] !== 5'b00000 || acc_q[1] !== 5'b00000 || acc_q[2] !== 5'b00001) begin
      mismatched++; $display("FAIL drain_events: got n=%0d expected 3 (press,press,release)", acc_q.size());
    end
    idle(4);
  endtask

  task automatic test_release_at_long();
    evt_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      btn_level = (c < LT) ? 5'b01000 : 5'b00000;
      step();
      compared++;
      if (obs !== exp_all() || long_press[3] !== 1'b0) begin
        mismatched++; $display("FAIL ral_cycle%0d: got %h expected %h", c, obs, exp_all());
      end
      if (c == LT) begin
        compared++;
        if (release_pulse[3] !== 1'b1) begin
          mismatched++; $display("FAIL ral_release: got %b expected 1", release_pulse[3]);
        end
      end
    end
    compared++;
    if (held !== 5'b00000) begin
      mismatched++; $display("FAIL ral_held: got %b expected 00000", held);
    end
    idle(6);
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0; btn_level = 5'b10000;
    for (int c = 0; c < 10; c++) step();
    compared++;
    if (held[4] !== 1'b1 || evt_valid !== 1'b1) begin
      mismatched++; $display("FAIL rm_setup: got held=%b valid=%b expected 1 1", held[4], evt_valid);
    end
    reset = 1'b1;
    step();
    compared++;
    if (obs !== 32'd0) begin
      mismatched++; $display("FAIL rm_reset: got %h expected %h", obs, 32'd0);
    end
    reset = 1'b0;
    step();
    compared++;
    if (press !== 5'b10000 || obs !== exp_all()) begin
      mismatched++; $display("FAIL rm_press: got %h expected %h", obs, exp_all());
    end
    idle(10);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 9) == 0) btn_level[b] = ~btn_level[b];
      evt_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
      compared++;
      if (obs !== exp_all()) begin
        mismatched++; $display("FAIL rand_cycle%0d: got %h expected %h", c, obs, exp_all());
      end
    end
    reset = 1'b0;
    idle(6);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) run_m[b] = 0;
    for (int k = 0; k < NB*4; k++) pend_m[k] = 1'b0;
    test_reset();
    test_press_release();
    test_long_repeat();
    test_simultaneous();
    test_stall_ovf();
    test_release_at_long();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
